img_stream_loader: RTL and testbench
====================================

Name: img_stream_loader

Overview:
- Upstream and downstream neighbour of the data RAM in the image-downsampling processor.
- Accepts the raw image as a byte stream with a valid/ready handshake and writes it sequentially into data RAM.
- Then pulses the processor to start, waits for its completion, and reads the downsampled region back out as a valid/ready byte stream.

Parameters:
- N_IN, 65536, number of input image bytes written starting at address 0.
- OUT_BASE, 16'h0000, first data RAM address of the downsampled result.
- N_OUT, 16384, number of result bytes streamed out (128x128).
- ADDR_W, 16, data RAM address width.
- CNT_W, 17, byte counter width; must hold N_IN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_load  input  1  begin a new frame; sampled only in IDLE.
- in_data  input  8  input pixel byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts in_data this cycle.
- mem_addr  output  ADDR_W  data RAM address (registered).
- mem_din  output  8  data RAM write data (registered).
- mem_write  output  1  data RAM write strobe, one cycle per byte.
- mem_read  output  1  data RAM read strobe, one cycle per byte.
- mem_dout  input  8  data RAM read data, valid the cycle after mem_read.
- proc_start  output  1  one-cycle pulse: image loaded, processor may run.
- proc_done  input  1  processor finished; level or pulse.
- out_data  output  8  result byte (registered).
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse after the last result byte is accepted.

Behaviour:
- Clock and reset: one clock domain (clk). rst is asynchronous, active-high.
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-operation aborts the frame. No partial write or read strobe is emitted after rst rises.
- States: IDLE, LOAD, PROC_START, PROC_WAIT, RD_ISSUE, RD_CAPTURE, OUT_HOLD, DONE.
- IDLE:
  - in_ready=0.
  - start_load=1 -> LOAD, cnt<=0.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, at the next edge: mem_addr<=cnt[ADDR_W-1:0], mem_din<=in_data, mem_write<=1, cnt<=cnt+1.
  - Otherwise mem_write<=0.
  - On the handshake with cnt==N_IN-1: in_ready drops next cycle and the state goes to PROC_START.
  - The final write strobe is still emitted in PROC_START's first cycle.
- PROC_START:
  - mem_write<=0, proc_start<=1 for exactly one cycle, then PROC_WAIT.
  - proc_start rises one cycle after the last mem_write cycle.
- PROC_WAIT:
  - Waits for proc_done=1, then cnt<=0 and RD_ISSUE.
  - proc_done outside PROC_WAIT is ignored.
- RD_ISSUE: mem_addr<=OUT_BASE+cnt (modulo 2^ADDR_W, wraps), mem_read<=1 for one cycle -> RD_CAPTURE.
- RD_CAPTURE:
  - mem_read=0; waits the RAM's one-cycle read latency.
  - At the end of this cycle: out_data<=mem_dout, out_valid<=1 -> OUT_HOLD.
- OUT_HOLD:
  - out_valid and out_data are held stable until out_ready=1.
  - On handshake: out_valid<=0, cnt<=cnt+1.
  - cnt==N_OUT-1 -> DONE; otherwise RD_ISSUE.
  - Throughput is 3 cycles per byte with out_ready tied high.
- DONE: frame_done=1 for one cycle -> IDLE.
- start_load is ignored outside IDLE. mem_write and mem_read are never high in the same cycle.
- Boundary conditions:
  - in_valid gaps in LOAD stall cnt; no write strobe is emitted.
  - N_IN=1 goes LOAD -> PROC_START after a single byte.
  - out_ready may be high before out_valid; it has no effect until OUT_HOLD.

Decomposition:
- Package img_pkg: state encoding localparams, default N_IN, N_OUT, OUT_BASE, ADDR_W, CNT_W. Shared with the processor and data RAM.
- One sub-module: out_stream_reg, an 8-bit output holding register with valid/ready. Its inputs are load, data and out_ready; its output is an accept pulse.
- The FSM and counter stay in the top module.

Test Plan:
- Reset mid-LOAD after 10 bytes -> next cycle all outputs 0, busy=0; a new start_load restarts at mem_addr 0.
- N_IN=4, bytes 0x11,0x22,0x33,0x44 with continuous in_valid -> mem_write 4 consecutive cycles at addresses 0..3 with matching mem_din; proc_start pulses 1 cycle after the last write; in_ready=0 afterwards.
- in_valid toggled 1,0,1,0 in LOAD -> exactly 2 writes at addresses 0,1; cnt holds during gaps; no extra strobes.
- proc_done asserted during LOAD -> ignored. Asserted in PROC_WAIT -> mem_read at OUT_BASE next cycle.
- N_OUT=3, OUT_BASE=16'hFFFF, RAM model returning addr[7:0] -> reads at FFFF, 0000, 0001; out_data FF, 00, 01; frame_done after the 3rd accept.
- out_ready held low 5 cycles in OUT_HOLD -> out_valid and out_data stable; no new mem_read until the handshake.

Source files
------------

// File: rtl/img_pkg.sv
// Shared definitions for the image-downsampling processor slice:
// default frame geometry and the loader state encoding.
package img_pkg;

  localparam int              DEF_ADDR_W   = 16;
  localparam int              DEF_CNT_W    = 17;
  localparam int              DEF_N_IN     = 65536;
  localparam int              DEF_N_OUT    = 16384;
  localparam logic [15:0]     DEF_OUT_BASE = 16'h0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PROC_START,
    S_PROC_WAIT,
    S_RD_ISSUE,
    S_RD_CAPTURE,
    S_OUT_HOLD,
    S_DONE
  } state_t;

endpackage

// File: rtl/img_stream_loader_if.sv
// Bundle of the loader's byte-stream, data-RAM and processor handshake signals.
// The loader drives the master view; the surrounding system uses the slave view.
interface img_stream_loader_if #(
  parameter int ADDR_W = img_pkg::DEF_ADDR_W
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_write;
  logic              mem_read;
  logic [7:0]        mem_dout;
  logic              proc_start;
  logic              proc_done;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  in_data, in_valid, mem_dout, proc_done, out_ready,
    output in_ready, mem_addr, mem_din, mem_write, mem_read, proc_start,
           out_data, out_valid
  );

  modport slave (
    output in_data, in_valid, mem_dout, proc_done, out_ready,
    input  in_ready, mem_addr, mem_din, mem_write, mem_read, proc_start,
           out_data, out_valid
  );

endinterface

// File: rtl/out_stream_reg.sv
// 8-bit output holding register: loads a byte, holds it with valid high
// until the consumer accepts it, and reports the accept as a pulse.
module out_stream_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_out_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_accept
);

  logic [7:0] r_data;
  logic       r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data   = r_data;
  assign o_valid  = r_valid;
  assign o_accept = r_valid & i_out_ready;

endmodule

// File: rtl/img_stream_loader.sv
// Writes an input byte stream into data RAM, kicks the processor, then streams
// the downsampled region back out of data RAM one byte per three cycles.
module img_stream_loader
  import img_pkg::*;
#(
  parameter int                N_IN     = DEF_N_IN,
  parameter int                N_OUT    = DEF_N_OUT,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                CNT_W    = DEF_CNT_W,
  parameter logic [ADDR_W-1:0] OUT_BASE = ADDR_W'(DEF_OUT_BASE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start_load,
  img_stream_loader_if.master io_bus,
  output logic                o_busy,
  output logic                o_frame_done
);

  state_t            r_state,      w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,        w_cnt_nxt;
  logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
  logic [7:0]        r_mem_din,    w_mem_din_nxt;
  logic              r_mem_write,  w_mem_write_nxt;
  logic              r_mem_read,   w_mem_read_nxt;
  logic              r_proc_start, w_proc_start_nxt;
  logic              w_out_load;
  logic              w_out_accept;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_last_in;
  logic              w_last_out;

  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_last_in  = (r_cnt == CNT_W'(N_IN - 1));
  assign w_last_out = (r_cnt == CNT_W'(N_OUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mem_addr   <= '0;
      r_mem_din    <= 8'h00;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_proc_start <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_din    <= w_mem_din_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_mem_read   <= w_mem_read_nxt;
      r_proc_start <= w_proc_start_nxt;
    end
  end

  // Strobes are computed one cycle early so the RAM sees them straight from flops;
  // a read is issued on entry to RD_ISSUE so its data lands during RD_CAPTURE.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_din_nxt    = r_mem_din;
    w_mem_write_nxt  = 1'b0;
    w_mem_read_nxt   = 1'b0;
    w_proc_start_nxt = 1'b0;
    w_out_load       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start_load) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (io_bus.in_valid) begin
          w_mem_addr_nxt  = r_cnt[ADDR_W-1:0];
          w_mem_din_nxt   = io_bus.in_data;
          w_mem_write_nxt = 1'b1;
          w_cnt_nxt       = w_cnt_inc;
          if (w_last_in) w_state_nxt = S_PROC_START;
        end
      end
      S_PROC_START: begin
        w_proc_start_nxt = 1'b1;
        w_state_nxt      = S_PROC_WAIT;
      end
      S_PROC_WAIT: begin
        if (io_bus.proc_done) begin
          w_cnt_nxt      = '0;
          w_mem_addr_nxt = OUT_BASE;
          w_mem_read_nxt = 1'b1;
          w_state_nxt    = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        w_state_nxt = S_RD_CAPTURE;
      end
      S_RD_CAPTURE: begin
        w_out_load  = 1'b1;
        w_state_nxt = S_OUT_HOLD;
      end
      S_OUT_HOLD: begin
        if (w_out_accept) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_last_out) begin
            w_state_nxt = S_DONE;
          end else begin
            w_mem_addr_nxt = OUT_BASE + w_cnt_inc[ADDR_W-1:0];
            w_mem_read_nxt = 1'b1;
            w_state_nxt    = S_RD_ISSUE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  out_stream_reg u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_out_load),
    .i_data      (io_bus.mem_dout),
    .i_out_ready (io_bus.out_ready),
    .o_data      (io_bus.out_data),
    .o_valid     (io_bus.out_valid),
    .o_accept    (w_out_accept)
  );

  assign io_bus.in_ready   = (r_state == S_LOAD);
  assign io_bus.mem_addr   = r_mem_addr;
  assign io_bus.mem_din    = r_mem_din;
  assign io_bus.mem_write  = r_mem_write;
  assign io_bus.mem_read   = r_mem_read;
  assign io_bus.proc_start = r_proc_start;
  assign o_busy            = (r_state != S_IDLE);
  assign o_frame_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_img_stream_loader.sv
// Directed bench: a small-frame loader (4 in, 3 out, base FFFF) for the full
// flow and a 16-byte loader for the mid-load reset case.
module tb_img_stream_loader;

  logic clk;
  logic rst;
  logic startA, startB;
  logic busyA, busyB, doneA, doneB;
  logic [7:0] ramDoutA;
  int errors;
  int checks;

  img_stream_loader_if #(.ADDR_W(16)) ifA ();
  img_stream_loader_if #(.ADDR_W(16)) ifB ();

  img_stream_loader #(
    .N_IN(4), .N_OUT(3), .ADDR_W(16), .CNT_W(17), .OUT_BASE(16'hFFFF)
  ) dutA (
    .clk(clk), .rst(rst), .i_start_load(startA), .io_bus(ifA),
    .o_busy(busyA), .o_frame_done(doneA)
  );

  img_stream_loader #(
    .N_IN(16), .N_OUT(2), .ADDR_W(16), .CNT_W(17), .OUT_BASE(16'h0000)
  ) dutB (
    .clk(clk), .rst(rst), .i_start_load(startB), .io_bus(ifB),
    .o_busy(busyB), .o_frame_done(doneB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model with one-cycle read latency that returns the low address byte.
  always @(posedge clk) begin
    if (ifA.mem_read) ramDoutA <= ifA.mem_addr[7:0];
  end
  assign ifA.mem_dout = ramDoutA;
  assign ifB.mem_dout = 8'h00;

  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    ramDoutA = 8'h00;
    rst = 1'b0;
    startA = 1'b0;
    startB = 1'b0;
    ifA.in_data = 8'h00; ifA.in_valid = 1'b0; ifA.proc_done = 1'b0; ifA.out_ready = 1'b0;
    ifB.in_data = 8'h00; ifB.in_valid = 1'b0; ifB.proc_done = 1'b0; ifB.out_ready = 1'b0;
    #1 rst = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
    applyStimulus(1);

    checkOutput("rst_busy", busyA, 0);
    checkOutput("rst_in_ready", ifA.in_ready, 0);
    checkOutput("rst_mem_write", ifA.mem_write, 0);
    checkOutput("rst_mem_read", ifA.mem_read, 0);
    checkOutput("rst_mem_addr", ifA.mem_addr, 0);
    checkOutput("rst_proc_start", ifA.proc_start, 0);
    checkOutput("rst_out_valid", ifA.out_valid, 0);
    checkOutput("rst_frame_done", doneA, 0);

    // Frame load of 4 bytes with proc_done asserted (and ignored) during LOAD
    startA = 1'b1;
    applyStimulus(1);
    startA = 1'b0;
    checkOutput("load_busy", busyA, 1);
    checkOutput("load_in_ready", ifA.in_ready, 1);
    ifA.proc_done = 1'b1;
    ifA.in_valid = 1'b1;
    ifA.in_data = 8'h11; applyStimulus(1);
    checkOutput("w0_write", ifA.mem_write, 1);
    checkOutput("w0_addr", ifA.mem_addr, 16'h0000);
    checkOutput("w0_din", ifA.mem_din, 8'h11);
    ifA.in_data = 8'h22; applyStimulus(1);
    checkOutput("w1_addr", ifA.mem_addr, 16'h0001);
    checkOutput("w1_din", ifA.mem_din, 8'h22);
    ifA.in_data = 8'h33; applyStimulus(1);
    checkOutput("w2_write", ifA.mem_write, 1);
    checkOutput("w2_addr", ifA.mem_addr, 16'h0002);
    checkOutput("w2_din", ifA.mem_din, 8'h33);
    ifA.in_data = 8'h44; applyStimulus(1);
    checkOutput("w3_write", ifA.mem_write, 1);
    checkOutput("w3_addr", ifA.mem_addr, 16'h0003);
    checkOutput("w3_din", ifA.mem_din, 8'h44);
    checkOutput("w3_in_ready", ifA.in_ready, 0);
    checkOutput("w3_proc_start", ifA.proc_start, 0);
    ifA.in_valid = 1'b0;
    ifA.proc_done = 1'b0;
    applyStimulus(1);
    checkOutput("ps_proc_start", ifA.proc_start, 1);
    checkOutput("ps_mem_write", ifA.mem_write, 0);
    checkOutput("ps_in_ready", ifA.in_ready, 0);
    applyStimulus(1);
    checkOutput("ps_pulse_end", ifA.proc_start, 0);
    checkOutput("wait_no_read", ifA.mem_read, 0);
    applyStimulus(2);
    checkOutput("wait_still", ifA.mem_read, 0);
    checkOutput("wait_busy", busyA, 1);

    // Readback: out_ready high early, byte 0 accepted immediately
    ifA.proc_done = 1'b1;
    ifA.out_ready = 1'b1;
    applyStimulus(1);
    ifA.proc_done = 1'b0;
    checkOutput("r0_read", ifA.mem_read, 1);
    checkOutput("r0_addr", ifA.mem_addr, 16'hFFFF);
    checkOutput("r0_out_valid_early", ifA.out_valid, 0);
    applyStimulus(1);
    checkOutput("r0_cap_read", ifA.mem_read, 0);
    applyStimulus(1);
    checkOutput("r0_valid", ifA.out_valid, 1);
    checkOutput("r0_data", ifA.out_data, 8'hFF);
    applyStimulus(1);
    checkOutput("r1_read", ifA.mem_read, 1);
    checkOutput("r1_addr", ifA.mem_addr, 16'h0000);
    checkOutput("r1_valid_drop", ifA.out_valid, 0);
    ifA.out_ready = 1'b0;
    applyStimulus(2);
    checkOutput("r1_data", ifA.out_data, 8'h00);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold%0d_valid", i), ifA.out_valid, 1);
      checkOutput($sformatf("hold%0d_data", i), ifA.out_data, 8'h00);
      checkOutput($sformatf("hold%0d_read", i), ifA.mem_read, 0);
      applyStimulus(1);
    end
    checkOutput("hold_end_valid", ifA.out_valid, 1);
    ifA.out_ready = 1'b1;
    applyStimulus(1);
    checkOutput("r2_read", ifA.mem_read, 1);
    checkOutput("r2_addr", ifA.mem_addr, 16'h0001);
    applyStimulus(2);
    checkOutput("r2_valid", ifA.out_valid, 1);
    checkOutput("r2_data", ifA.out_data, 8'h01);
    checkOutput("r2_no_done", doneA, 0);
    applyStimulus(1);
    checkOutput("fd_pulse", doneA, 1);
    checkOutput("fd_valid_drop", ifA.out_valid, 0);
    checkOutput("fd_no_read", ifA.mem_read, 0);
    applyStimulus(1);
    checkOutput("fd_end", doneA, 0);
    checkOutput("idle_busy", busyA, 0);

    // Gapped in_valid: 1,0,1,0 gives exactly two writes at 0 and 1
    startA = 1'b1;
    applyStimulus(1);
    startA = 1'b0;
    ifA.in_valid = 1'b1; ifA.in_data = 8'hAA; applyStimulus(1);
    checkOutput("g0_write", ifA.mem_write, 1);
    checkOutput("g0_addr", ifA.mem_addr, 16'h0000);
    checkOutput("g0_din", ifA.mem_din, 8'hAA);
    ifA.in_valid = 1'b0; ifA.in_data = 8'hBB; applyStimulus(1);
    checkOutput("g1_write", ifA.mem_write, 0);
    ifA.in_valid = 1'b1; ifA.in_data = 8'hCC; applyStimulus(1);
    checkOutput("g2_write", ifA.mem_write, 1);
    checkOutput("g2_addr", ifA.mem_addr, 16'h0001);
    checkOutput("g2_din", ifA.mem_din, 8'hCC);
    ifA.in_valid = 1'b0; applyStimulus(1);
    checkOutput("g3_write", ifA.mem_write, 0);
    checkOutput("g3_in_ready", ifA.in_ready, 1);

    // Mid-load reset on the 16-byte loader after 10 bytes
    startB = 1'b1;
    applyStimulus(1);
    startB = 1'b0;
    ifB.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ifB.in_data = 8'(i + 1);
      applyStimulus(1);
    end
    checkOutput("b9_write", ifB.mem_write, 1);
    checkOutput("b9_addr", ifB.mem_addr, 16'h0009);
    checkOutput("b9_din", ifB.mem_din, 8'h0A);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_write", ifB.mem_write, 0);
    checkOutput("arst_addr", ifB.mem_addr, 16'h0000);
    checkOutput("arst_din", ifB.mem_din, 8'h00);
    checkOutput("arst_in_ready", ifB.in_ready, 0);
    checkOutput("arst_busy", busyB, 0);
    applyStimulus(1);
    checkOutput("arst_hold_write", ifB.mem_write, 0);
    rst = 1'b0;
    ifB.in_data = 8'h5A;
    applyStimulus(1);
    checkOutput("post_rst_idle", busyB, 0);
    startB = 1'b1;
    applyStimulus(1);
    startB = 1'b0;
    applyStimulus(1);
    checkOutput("restart_write", ifB.mem_write, 1);
    checkOutput("restart_addr", ifB.mem_addr, 16'h0000);
    checkOutput("restart_din", ifB.mem_din, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
